// File: rtl/irq_source_gateway.sv
// Interrupt source gateway: conditions raw IRQ lines into PLIC-ready levels.
// Per source: optional 2-flop synchronizer, level pass-through or edge-pending FSM with missed-edge counter.
module irq_source_gateway #(
    parameter int                    NumSources = 30,
    parameter logic [NumSources-1:0] EdgeMask   = NumSources'(32'h0000_0780),
    parameter logic [NumSources-1:0] SyncMask   = NumSources'(32'h0000_0004),
    parameter int                    CntWidth   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumSources-1:0]          irq_i,
    input  logic [NumSources-1:0]          complete_i,
    input  logic                           miss_clr_i,
    output logic [NumSources-1:0]          irq_o,
    output logic [NumSources*CntWidth-1:0] miss_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pend_state_e;

    logic [NumSources-1:0] s;

    // Level sources never look at completions; keep those bits visibly consumed.
    logic unused_level_inputs;
    assign unused_level_inputs = ^(complete_i & ~EdgeMask) ^ miss_clr_i;

    for (genvar k = 0; k < NumSources; k++) begin : g_src

        if (SyncMask[k]) begin : g_sync
            logic [1:0] sync_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[0], irq_i[k]};
                end
            end

            assign s[k] = sync_q[1];
        end else begin : g_direct
            assign s[k] = irq_i[k];
        end

        if (EdgeMask[k]) begin : g_edge
            logic                prev_q;
            logic                rise;
            logic                inc;
            pend_state_e         state_q;
            pend_state_e         state_d;
            logic [CntWidth-1:0] cnt_q;

            assign rise = s[k] & ~prev_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    prev_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    prev_q  <= s[k];
                    state_q <= state_d;
                end
            end

            // A fresh edge always wins over a completion in the same cycle.
            always_comb begin
                state_d = state_q;
                inc     = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_d = PEND;
                        end
                    end
                    PEND: begin
                        if (rise) begin
                            inc = ~complete_i[k];
                        end else if (complete_i[k]) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || miss_clr_i) begin
                    cnt_q <= '0;
                end else if (inc && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + CntWidth'(1);
                end
            end

            assign irq_o[k]                              = (state_q == PEND);
            assign miss_cnt_o[k*CntWidth +: CntWidth]    = cnt_q;
        end else begin : g_level
            logic level_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    level_q <= 1'b0;
                end else begin
                    level_q <= s[k];
                end
            end

            assign irq_o[k]                              = level_q;
            assign miss_cnt_o[k*CntWidth +: CntWidth]    = '0;
        end
    end

endmodule

// File: tb/tb_irq_source_gateway.sv
// Directed bench for irq_source_gateway: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them when their cycle comes up.
module tb_irq_source_gateway;

    localparam int N  = 30;
    localparam int CW = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    irq;
    logic [N-1:0]    cpl;
    logic            clr;
    logic [N-1:0]    irq_out;
    logic [N*CW-1:0] cnt_out;

    logic [N-1:0]    irq_v;
    logic [N-1:0]    cpl_v;

    int cyc          = 0;
    int n_vectors    = 0;
    int n_miscompare = 0;

    typedef struct packed {
        int           cycle;
        logic [1:0]   kind;
        logic [7:0]   src;
        logic [31:0]  exp;
        logic [127:0] name;
    } exp_t;

    exp_t sb_q[$];

    irq_source_gateway dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .irq_i      (irq),
        .complete_i (cpl),
        .miss_clr_i (clr),
        .irq_o      (irq_out),
        .miss_cnt_o (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [N-1:0] i_v, input logic [N-1:0] c_v,
                                 input logic cl, input logic r);
        irq = i_v;
        cpl = c_v;
        clr = cl;
        rst = r;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 = irq_o bit, 1 = counter of src, 2 = whole irq_o vector
    task automatic expectAt(input int delay, input logic [127:0] name, input logic [1:0] kind,
                            input int src, input logic [31:0] value);
        exp_t e;
        e.cycle = cyc + delay;
        e.kind  = kind;
        e.src   = 8'(src);
        e.exp   = value;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        case (e.kind)
            2'd0:    act = 32'(irq_out[e.src]);
            2'd1:    act = 32'(cnt_out[int'(e.src)*CW +: CW]);
            default: act = 32'(irq_out);
        endcase
        n_vectors++;
        if (act !== e.exp) begin
            n_miscompare++;
            $display("[TB] FAIL %0s (src %0d, cycle %0d): got %0h, expected %0h",
                     e.name, e.src, cyc, act, e.exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cycle == cyc) begin
                checkOutput(sb_q[i]);
                sb_q.delete(i);
            end
        end
    end

    task automatic pulseEdge(input int src);
        irq_v[src] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
        irq_v[src] = 1'b0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
    endtask

    initial begin
        irq_v = '0;
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b1);
        tick(2);
        expectAt(0, "rst_irq", 2, 0, 0);
        expectAt(0, "rst_cnt8", 1, 8, 0);
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(2);

        // Edge source 7: held high, then completed
        irq_v[7] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(0, "a_pre", 0, 7, 0);
        expectAt(1, "a_rise", 0, 7, 1);
        for (int d = 2; d <= 5; d++) expectAt(d, "a_hold", 0, 7, 1);
        tick(5);
        irq_v[7] = 1'b0;
        cpl_v[7] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "a_cleared", 0, 7, 0);
        expectAt(1, "a_cnt", 1, 7, 0);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);

        // Edge source 8: missed-edge counting, saturation, clear
        irq_v[8] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "b_pend", 0, 8, 1);
        tick(1);
        irq_v[8] = 1'b0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
        repeat (3) pulseEdge(8);
        expectAt(0, "b_cnt3", 1, 8, 3);
        repeat (9) pulseEdge(8);
        expectAt(0, "b_cnt12", 1, 8, 12);
        repeat (8) pulseEdge(8);
        expectAt(0, "b_sat", 1, 8, 15);
        pulseEdge(8);
        expectAt(0, "b_nowrap", 1, 8, 15);
        irq_v[8] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b1, 1'b0);
        expectAt(1, "b_clr", 1, 8, 0);
        expectAt(1, "b_clr_pend", 0, 8, 1);
        tick(1);
        irq_v[8] = 1'b0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
        pulseEdge(8);
        expectAt(0, "b_after_clr", 1, 8, 1);
        cpl_v[8] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "b_done", 0, 8, 0);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);

        // Edge source 9: edge racing a completion, completion while idle
        irq_v[9] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "c_pend", 0, 9, 1);
        tick(1);
        irq_v[9] = 1'b0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
        irq_v[9] = 1'b1;
        cpl_v[9] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "c_race_irq", 0, 9, 1);
        expectAt(1, "c_race_cnt", 1, 9, 0);
        tick(1);
        irq_v[9] = 1'b0;
        cpl_v    = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
        cpl_v[9] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "c_cpl", 0, 9, 0);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
        cpl_v[9] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "c_idle_cpl", 0, 9, 0);
        expectAt(1, "c_idle_cnt", 1, 9, 0);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);

        // Level source 2 behind the synchronizer
        irq_v[2] = 1'b1;
        cpl_v[2] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(2, "d_lat2", 0, 2, 0);
        expectAt(3, "d_lat3", 0, 2, 1);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(3);
        cpl_v[2] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "d_cpl_ignored", 0, 2, 1);
        tick(1);
        cpl_v    = '0;
        irq_v[2] = 1'b0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(2, "d_fall2", 0, 2, 1);
        expectAt(3, "d_fall3", 0, 2, 0);
        expectAt(3, "d_cnt", 1, 2, 0);
        tick(4);

        // Level source 0, direct
        irq_v[0] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(0, "e_before", 0, 0, 0);
        expectAt(1, "e_lat1", 0, 0, 1);
        tick(2);
        irq_v[0] = 1'b0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "e_fall", 0, 0, 0);
        tick(2);

        // Simultaneous events on several sources
        irq_v[7] = 1'b1;
        irq_v[9] = 1'b1;
        irq_v[0] = 1'b1;
        cpl_v[8] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "f_s7", 0, 7, 1);
        expectAt(1, "f_s9", 0, 9, 1);
        expectAt(1, "f_s0", 0, 0, 1);
        expectAt(1, "f_s8", 0, 8, 0);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);
        irq_v[7] = 1'b0;
        irq_v[9] = 1'b0;
        irq_v[0] = 1'b0;
        cpl_v[7] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "f_c7", 0, 7, 0);
        expectAt(1, "f_keep9", 0, 9, 1);
        expectAt(1, "f_c0", 0, 0, 0);
        tick(1);
        cpl_v    = '0;
        cpl_v[9] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "f_c9", 0, 9, 0);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(1);

        // Edge source 10: reset mid-PEND, level held across release
        pulseEdge(10);
        pulseEdge(10);
        pulseEdge(10);
        expectAt(0, "g_cnt2", 1, 10, 2);
        expectAt(0, "g_pend", 0, 10, 1);
        irq_v[10] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b1);
        expectAt(1, "g_rst_irq", 2, 0, 0);
        expectAt(1, "g_rst_cnt10", 1, 10, 0);
        expectAt(1, "g_rst_cnt8", 1, 8, 0);
        tick(2);
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(0, "g_rel_low", 0, 10, 0);
        expectAt(1, "g_rel_pend", 0, 10, 1);
        tick(4);
        expectAt(0, "g_one_edge", 1, 10, 0);
        cpl_v[10] = 1'b1;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        expectAt(1, "g_cpl", 0, 10, 0);
        expectAt(2, "g_stay_idle", 0, 10, 0);
        tick(1);
        cpl_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(2);
        irq_v = '0;
        applyStimulus(irq_v, cpl_v, 1'b0, 1'b0);
        tick(4);

        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vectors++;
            n_miscompare++;
            $display("[TB] FAIL %0s: expectation for cycle %0d never checked, expected %0h",
                     e.name, e.cycle, e.exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule
